// File: rtl/tx_frame_builder.sv
// tx_frame_builder: buffers one payload frame, then streams header, payload
// and checksum words into the transmitter FIFO write port.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// COLLECT   | accepting payload words into the buffer (s_ready=1)
// SEND_HDR  | header {SOF_MARK, len} presented, waiting for its write
// SEND_PAY  | buf[idx] presented, idx advances on each write
// SEND_CSUM | checksum presented; its write completes the frame
module tx_frame_builder #(
   parameter int unsigned MAX_LEN  = 64,
   parameter logic [7:0]  SOF_MARK = 8'hA5
) (
   input  logic        clk_tx,
   input  logic        rst_tx,
   input  logic [15:0] s_data,
   input  logic        s_valid,
   input  logic        s_last,
   output logic        s_ready,
   output logic [15:0] tx_data,
   output logic        tx_wr_en,
   input  logic        tx_fifo_full,
   output logic        truncated,
   output logic [15:0] frame_count,
   output logic        busy
);

   localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0]  LEN_MAX = 8'(MAX_LEN);

   localparam logic [1:0] ST_COLLECT   = 2'd0;
   localparam logic [1:0] ST_SEND_HDR  = 2'd1;
   localparam logic [1:0] ST_SEND_PAY  = 2'd2;
   localparam logic [1:0] ST_SEND_CSUM = 2'd3;

   logic [1:0]  state_q, state_d;
   logic [7:0]  len_q, len_d;
   logic [15:0] acc_q, acc_d;
   logic [7:0]  idx_q, idx_d;
   logic [15:0] data_q, data_d;
   logic        pend_q, pend_d;
   logic        trunc_q, trunc_d;
   logic [15:0] fcnt_q, fcnt_d;

   logic [15:0] buf_q [MAX_LEN];

   logic          accept;
   logic          wr_fire;
   logic [7:0]    len_inc;
   logic [15:0]   hdr_word;
   logic [15:0]   csum;
   logic [AW-1:0] wr_addr;
   logic [AW-1:0] rd_addr;
   logic [15:0]   rd_word;

   // s_ready is gated by reset so no word can be taken while reset is held
   assign s_ready     = (state_q == ST_COLLECT) && !rst_tx;
   assign accept      = s_valid && s_ready;
   assign tx_wr_en    = pend_q && !tx_fifo_full;
   assign wr_fire     = tx_wr_en;
   assign tx_data     = data_q;
   assign truncated   = trunc_q;
   assign frame_count = fcnt_q;
   assign busy        = (state_q != ST_COLLECT);

   assign len_inc  = len_q + 8'd1;
   assign hdr_word = {SOF_MARK, len_q};
   // checksum makes the 16-bit sum of header, payload and checksum zero
   assign csum     = 16'd0 - (acc_q + hdr_word);
   assign wr_addr  = len_q[AW-1:0];
   // header write preloads word 0; payload writes preload the following word
   assign rd_addr  = (state_q == ST_SEND_HDR) ? '0 : (idx_q[AW-1:0] + AW'(1));
   assign rd_word  = buf_q[rd_addr];

   // payload storage, written once per accepted word
   always_ff @(posedge clk_tx) begin
      if (accept) begin
         buf_q[wr_addr] <= s_data;
      end
   end

   // frame FSM and output word sequencing
   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      acc_d   = acc_q;
      idx_d   = idx_q;
      data_d  = data_q;
      pend_d  = pend_q;
      trunc_d = 1'b0;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_COLLECT: begin
            if (accept) begin
               len_d = len_inc;
               acc_d = acc_q + s_data;
               if (s_last || (len_inc == LEN_MAX)) begin
                  state_d = ST_SEND_HDR;
                  data_d  = {SOF_MARK, len_inc};
                  pend_d  = 1'b1;
                  trunc_d = !s_last;
               end
            end
         end
         ST_SEND_HDR: begin
            if (wr_fire) begin
               state_d = ST_SEND_PAY;
               idx_d   = 8'd0;
               data_d  = rd_word;
            end
         end
         ST_SEND_PAY: begin
            if (wr_fire) begin
               if (idx_q == (len_q - 8'd1)) begin
                  state_d = ST_SEND_CSUM;
                  data_d  = csum;
               end else begin
                  idx_d  = idx_q + 8'd1;
                  data_d = rd_word;
               end
            end
         end
         ST_SEND_CSUM: begin
            if (wr_fire) begin
               state_d = ST_COLLECT;
               pend_d  = 1'b0;
               fcnt_d  = fcnt_q + 16'd1;
               len_d   = 8'd0;
               acc_d   = 16'd0;
            end
         end
         default: begin
            state_d = ST_COLLECT;
            pend_d  = 1'b0;
         end
      endcase
   end

   // state registers; reset discards any partial frame and drops the write strobe
   always_ff @(posedge clk_tx or posedge rst_tx) begin
      if (rst_tx) begin
         state_q <= ST_COLLECT;
         len_q   <= 8'd0;
         acc_q   <= 16'd0;
         idx_q   <= 8'd0;
         data_q  <= 16'd0;
         pend_q  <= 1'b0;
         trunc_q <= 1'b0;
         fcnt_q  <= 16'd0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         acc_q   <= acc_d;
         idx_q   <= idx_d;
         data_q  <= data_d;
         pend_q  <= pend_d;
         trunc_q <= trunc_d;
         fcnt_q  <= fcnt_d;
      end
   end

endmodule

// File: tb/tb_tx_frame_builder.sv
// Directed bench for tx_frame_builder: a MAX_LEN=64 instance for the main
// cases and a MAX_LEN=4 instance for forced truncation.
module tb_tx_frame_builder;

   logic clk_tx = 1'b0;
   always #5 clk_tx = ~clk_tx;

   logic        rst_tx;
   logic [15:0] s_data;
   logic        s_valid, s_last, tx_fifo_full;
   logic        sel;
   logic        s_valid_a, s_valid_b;

   logic        s_ready_a, tx_wr_en_a, truncated_a, busy_a;
   logic [15:0] tx_data_a, frame_count_a;
   logic        s_ready_b, tx_wr_en_b, truncated_b, busy_b;
   logic [15:0] tx_data_b, frame_count_b;

   assign s_valid_a = s_valid && !sel;
   assign s_valid_b = s_valid && sel;

   tx_frame_builder #(.MAX_LEN(64), .SOF_MARK(8'hA5)) u_dut_a (
      .clk_tx(clk_tx), .rst_tx(rst_tx), .s_data(s_data), .s_valid(s_valid_a),
      .s_last(s_last), .s_ready(s_ready_a), .tx_data(tx_data_a), .tx_wr_en(tx_wr_en_a),
      .tx_fifo_full(tx_fifo_full), .truncated(truncated_a),
      .frame_count(frame_count_a), .busy(busy_a)
   );

   tx_frame_builder #(.MAX_LEN(4), .SOF_MARK(8'hA5)) u_dut_b (
      .clk_tx(clk_tx), .rst_tx(rst_tx), .s_data(s_data), .s_valid(s_valid_b),
      .s_last(s_last), .s_ready(s_ready_b), .tx_data(tx_data_b), .tx_wr_en(tx_wr_en_b),
      .tx_fifo_full(tx_fifo_full), .truncated(truncated_b),
      .frame_count(frame_count_b), .busy(busy_b)
   );

   int cyc = 0;
   always @(posedge clk_tx) cyc <= cyc + 1;

   logic [15:0] q_a[$], q_b[$], exp_q[$];
   int          st_a[$];
   int          acc_cyc[$];
   int          trunc_cnt_a = 0, trunc_cnt_b = 0, trunc_cyc_b = -1;

   // capture every word actually written, with the cycle it was written in
   always @(posedge clk_tx) begin
      if (tx_wr_en_a) begin
         q_a.push_back(tx_data_a);
         st_a.push_back(cyc);
      end
      if (tx_wr_en_b) q_b.push_back(tx_data_b);
      if (truncated_a) trunc_cnt_a++;
      if (truncated_b) begin
         trunc_cnt_b++;
         trunc_cyc_b = cyc;
      end
   end

   int n_chk = 0, n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic int stamp_a(input int i);
      return (i < st_a.size()) ? st_a[i] : -1;
   endfunction

   // called at a negedge; waits (bounded) for s_ready then offers one word
   task automatic send_word(input logic [15:0] d, input logic last);
      int g = 0;
      while (!(sel ? s_ready_b : s_ready_a) && g < 200) begin
         @(negedge clk_tx);
         g++;
      end
      if (g >= 200) chk("ready_wait", 32'(sel ? s_ready_b : s_ready_a), 32'd1);
      s_data  = d;
      s_valid = 1'b1;
      s_last  = last;
      acc_cyc.push_back(cyc);
      @(negedge clk_tx);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic goto_cyc(input int c);
      int g = 0;
      while (cyc < c && g < 2000) begin
         @(negedge clk_tx);
         g++;
      end
   endtask

   task automatic cmp_q(input string tag, input bit which);
      int sz;
      logic [31:0] obs;
      sz = which ? q_b.size() : q_a.size();
      chk({tag, "_len"}, 32'(sz), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < sz) obs = 32'(which ? q_b[i] : q_a[i]);
         else obs = 32'hFFFF_FFFF;
         chk($sformatf("%s[%0d]", tag, i), obs, 32'(exp_q[i]));
      end
   endtask

   task automatic clear_caps();
      q_a.delete();
      q_b.delete();
      st_a.delete();
      acc_cyc.delete();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int n, held;
      logic [15:0] s;
      sel = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = 16'h0;
      tx_fifo_full = 1'b0; rst_tx = 1'b1;

      // reset values
      repeat (3) @(negedge clk_tx);
      chk("rst_ready", 32'(s_ready_a), 32'd0);
      chk("rst_wr_en", 32'(tx_wr_en_a), 32'd0);
      chk("rst_data", 32'(tx_data_a), 32'd0);
      chk("rst_trunc", 32'(truncated_a), 32'd0);
      chk("rst_fcount", 32'(frame_count_a), 32'd0);
      chk("rst_busy", 32'(busy_a), 32'd0);
      rst_tx = 1'b0;
      @(negedge clk_tx);
      chk("rel_ready", 32'(s_ready_a), 32'd1);

      // single word: 0x1234 + 0xA501 = 0xB735 -> csum 0x48CB
      clear_caps();
      send_word(16'h1234, 1'b1);
      n = acc_cyc[0];
      goto_cyc(n + 3);
      chk("single_busy_last", 32'(busy_a), 32'd1);
      chk("single_ready_last", 32'(s_ready_a), 32'd0);
      chk("single_fc_before", 32'(frame_count_a), 32'd0);
      goto_cyc(n + 4);
      chk("single_ready_back", 32'(s_ready_a), 32'd1);
      chk("single_fc", 32'(frame_count_a), 32'd1);
      exp_q = '{16'hA501, 16'h1234, 16'h48CB};
      cmp_q("single", 1'b0);
      chk("single_first_cyc", 32'(stamp_a(0)), 32'(n + 1));
      chk("single_last_cyc", 32'(stamp_a(2)), 32'(n + 3));

      // three words: payload sum 0x0001, + 0xA503 = 0xA504 -> csum 0x5AFC
      clear_caps();
      send_word(16'hAAAA, 1'b0);
      send_word(16'hAAAB, 1'b0);
      send_word(16'hAAAC, 1'b1);
      n = acc_cyc[2];
      goto_cyc(n + 6);
      exp_q = '{16'hA503, 16'hAAAA, 16'hAAAB, 16'hAAAC, 16'h5AFC};
      cmp_q("three", 1'b0);
      chk("three_first_cyc", 32'(stamp_a(0)), 32'(n + 1));
      chk("three_last_cyc", 32'(stamp_a(4)), 32'(n + 5));
      chk("three_fc", 32'(frame_count_a), 32'd2);

      // back-pressure: full for 5 cycles after the first payload write
      clear_caps();
      send_word(16'hAAAA, 1'b0);
      send_word(16'hAAAB, 1'b0);
      send_word(16'hAAAC, 1'b1);
      n = acc_cyc[2];
      goto_cyc(n + 3);
      for (int k = 0; k < 5; k++) begin
         tx_fifo_full = 1'b1;
         #1;
         chk($sformatf("bp_wr_en_%0d", k), 32'(tx_wr_en_a), 32'd0);
         chk($sformatf("bp_data_%0d", k), 32'(tx_data_a), 32'hAAAB);
         @(negedge clk_tx);
      end
      tx_fifo_full = 1'b0;
      goto_cyc(n + 12);
      exp_q = '{16'hA503, 16'hAAAA, 16'hAAAB, 16'hAAAC, 16'h5AFC};
      cmp_q("bp", 1'b0);
      chk("bp_pay0_cyc", 32'(stamp_a(1)), 32'(n + 2));
      chk("bp_pay1_cyc", 32'(stamp_a(2)), 32'(n + 8));
      chk("bp_csum_cyc", 32'(stamp_a(4)), 32'(n + 10));
      chk("bp_fc", 32'(frame_count_a), 32'd3);

      // truncation on the MAX_LEN=4 instance
      // frame 1: 1+2+3+4 = 0x000A, + 0xA504 = 0xA50E -> 0x5AF2
      // frame 2: 5+6 = 0x000B, + 0xA502 = 0xA50D -> 0x5AF3
      clear_caps();
      sel = 1'b1;
      for (int i = 1; i <= 6; i++) send_word(16'(i), (i == 6));
      n = acc_cyc[5];
      goto_cyc(n + 6);
      exp_q = '{16'hA504, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h5AF2,
                16'hA502, 16'h0005, 16'h0006, 16'h5AF3};
      cmp_q("trunc", 1'b1);
      chk("trunc_pulses", 32'(trunc_cnt_b), 32'd1);
      chk("trunc_cyc", 32'(trunc_cyc_b), 32'(acc_cyc[3] + 1));
      chk("trunc_resume_cyc", 32'(acc_cyc[4]), 32'(acc_cyc[3] + 7));
      chk("trunc_fc", 32'(frame_count_b), 32'd2);
      chk("trunc_none_on_a", 32'(trunc_cnt_a), 32'd0);
      sel = 1'b0;

      // reset during payload of a 10-word frame
      clear_caps();
      for (int i = 0; i < 10; i++) send_word(16'h0100 + 16'(i), (i == 9));
      n = acc_cyc[9];
      goto_cyc(n + 5);
      chk("mid_wr_en_pre", 32'(tx_wr_en_a), 32'd1);
      chk("mid_busy_pre", 32'(busy_a), 32'd1);
      rst_tx = 1'b1;
      #1;
      chk("mid_wr_en_rst", 32'(tx_wr_en_a), 32'd0);
      chk("mid_ready_rst", 32'(s_ready_a), 32'd0);
      chk("mid_busy_rst", 32'(busy_a), 32'd0);
      held = q_a.size();
      chk("mid_writes_before", 32'(held), 32'd4);
      repeat (2) @(negedge clk_tx);
      rst_tx = 1'b0;
      repeat (20) @(negedge clk_tx);
      chk("mid_no_more_writes", 32'(q_a.size()), 32'(held));
      chk("mid_fc", 32'(frame_count_a), 32'd0);
      clear_caps();
      send_word(16'h0000, 1'b1);
      n = acc_cyc[0];
      goto_cyc(n + 5);
      exp_q = '{16'hA501, 16'h0000, 16'h5AFF};
      cmp_q("post_rst", 1'b0);
      chk("post_rst_fc", 32'(frame_count_a), 32'd1);

      // five 8-word frames back to back from a fresh reset
      rst_tx = 1'b1;
      repeat (2) @(negedge clk_tx);
      rst_tx = 1'b0;
      @(negedge clk_tx);
      clear_caps();
      exp_q.delete();
      for (int f = 0; f < 5; f++) begin
         s = 16'hA508;
         exp_q.push_back(16'hA508);
         for (int w = 0; w < 8; w++) begin
            send_word(16'hAAAA + 16'(f * 8 + w), (w == 7));
            exp_q.push_back(16'hAAAA + 16'(f * 8 + w));
            s = s + 16'hAAAA + 16'(f * 8 + w);
         end
         exp_q.push_back(16'h0000 - s);
      end
      goto_cyc(acc_cyc[39] + 12);
      cmp_q("e2e", 1'b0);
      for (int f = 0; f < 5; f++) begin
         s = 16'h0;
         for (int i = 0; i < 10; i++)
            if (f * 10 + i < q_a.size()) s = s + q_a[f * 10 + i];
         chk($sformatf("e2e_sum_%0d", f), 32'(s), 32'd0);
      end
      chk("e2e_fc", 32'(frame_count_a), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
